// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spike onsets over a programmable window
// and measures the last inter-spike interval inside that window.
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_enable            run back-to-back windows while high
//   i_spike_in          spike level from the neuron
//   i_window_len        window is i_window_len+1 cycles, sampled at window start
//   o_rate_out          onsets in the last published window (saturating)
//   o_isi_out           cycles between last two onsets, 0 if fewer than 2
//   o_out_valid         result pending; i_out_ready accepts it
//   o_overrun           sticky: a result was dropped under backpressure
//   o_busy              high while counting
module spike_rate_decoder #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_spike_in,
    input  logic [WIN_W-1:0] i_window_len,
    output logic [CNT_W-1:0] o_rate_out,
    output logic [CNT_W-1:0] o_isi_out,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_overrun,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] MAXV = '1;

    typedef enum logic {
        S_IDLE,
        S_COUNT
    } state_t;

    state_t           r_state;
    logic             r_spike_q;
    logic [WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_isi_tmr;
    logic             r_seen;
    logic [CNT_W-1:0] r_isi_last;

    logic             w_onset;
    logic             w_publish;
    logic             w_xfer;
    logic [CNT_W-1:0] w_acc_inc;
    logic [CNT_W-1:0] w_tmr_inc;
    logic [CNT_W-1:0] w_pub_rate;
    logic [CNT_W-1:0] w_pub_isi;

    assign w_onset   = i_spike_in & ~r_spike_q;
    assign w_publish = (r_state == S_COUNT) & i_enable & (r_win_cnt == '0);
    assign w_xfer    = o_out_valid & i_out_ready;
    assign w_acc_inc = (r_acc == MAXV) ? MAXV : r_acc + CNT_W'(1);
    assign w_tmr_inc = (r_isi_tmr == MAXV) ? MAXV : r_isi_tmr + CNT_W'(1);

    // An onset on the final window cycle still belongs to this window,
    // so fold it into the published values directly.
    assign w_pub_rate = w_onset ? w_acc_inc : r_acc;
    assign w_pub_isi  = (w_onset & r_seen) ? r_isi_tmr : r_isi_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_spike_q   <= 1'b0;
            r_win_cnt   <= '0;
            r_acc       <= '0;
            r_isi_tmr   <= '0;
            r_seen      <= 1'b0;
            r_isi_last  <= '0;
            o_rate_out  <= '0;
            o_isi_out   <= '0;
            o_out_valid <= 1'b0;
            o_overrun   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            r_spike_q <= i_spike_in;

            // A transfer on the publish cycle frees the slot for the new result.
            if (w_publish) begin
                if (!o_out_valid || w_xfer) begin
                    o_rate_out  <= w_pub_rate;
                    o_isi_out   <= w_pub_isi;
                    o_out_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (w_xfer) begin
                o_out_valid <= 1'b0;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (i_enable) begin
                        r_state    <= S_COUNT;
                        o_busy     <= 1'b1;
                        r_win_cnt  <= i_window_len;
                        r_acc      <= '0;
                        r_isi_tmr  <= '0;
                        r_seen     <= 1'b0;
                        r_isi_last <= '0;
                    end
                end
                S_COUNT: begin
                    if (!i_enable) begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                    end else if (r_win_cnt == '0) begin
                        r_win_cnt  <= i_window_len;
                        r_acc      <= '0;
                        r_isi_tmr  <= '0;
                        r_seen     <= 1'b0;
                        r_isi_last <= '0;
                    end else begin
                        r_win_cnt <= r_win_cnt - WIN_W'(1);
                        if (w_onset) begin
                            r_acc     <= w_acc_inc;
                            r_isi_tmr <= CNT_W'(1);
                            r_seen    <= 1'b1;
                            if (r_seen)
                                r_isi_last <= r_isi_tmr;
                        end else begin
                            r_isi_tmr <= w_tmr_inc;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: onset-time model plus directed checks.
// CNT_W is narrowed to 4 so saturation is reachable.
module tb_spike_rate_decoder;

    localparam int CNT_W = 4;
    localparam int WIN_W = 8;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en  = 1'b0;
    logic             spk = 1'b0;
    logic             rdy = 1'b0;
    logic [WIN_W-1:0] wlen = '0;
    logic [CNT_W-1:0] rate;
    logic [CNT_W-1:0] isi;
    logic             valid;
    logic             ovr;
    logic             busy;

    spike_rate_decoder #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_enable     (en),
        .i_spike_in   (spk),
        .i_window_len (wlen),
        .o_rate_out   (rate),
        .o_isi_out    (isi),
        .o_out_valid  (valid),
        .i_out_ready  (rdy),
        .o_overrun    (ovr),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // Model: a window is a list of onset positions; results follow from it.
    bit m_prev  = 1'b0;
    bit m_run   = 1'b0;
    bit m_valid = 1'b0;
    bit m_ovr   = 1'b0;
    int m_rate  = 0;
    int m_isi   = 0;
    int m_pos   = 0;
    int m_len   = 0;
    int m_q[$];
    bit m_onset;
    bit m_pub;
    bit m_xfer;
    int m_nr;
    int m_ni;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev  = 1'b0;
            m_run   = 1'b0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_rate  = 0;
            m_isi   = 0;
            m_pos   = 0;
            m_len   = 0;
            m_q.delete();
        end else begin
            m_onset = spk && !m_prev;
            m_prev  = spk;
            m_pub   = 1'b0;
            m_xfer  = m_valid && rdy;
            m_nr    = 0;
            m_ni    = 0;
            if (!m_run) begin
                if (en) begin
                    m_run = 1'b1;
                    m_len = int'(wlen);
                    m_pos = 0;
                    m_q.delete();
                end
            end else if (!en) begin
                m_run = 1'b0;
            end else begin
                if (m_onset) m_q.push_back(m_pos);
                if (m_pos == m_len) begin
                    m_pub = 1'b1;
                    m_nr  = (m_q.size() > MAXV) ? MAXV : m_q.size();
                    if (m_q.size() >= 2) begin
                        m_ni = m_q[m_q.size()-1] - m_q[m_q.size()-2];
                        if (m_ni > MAXV) m_ni = MAXV;
                    end
                    m_pos = 0;
                    m_len = int'(wlen);
                    m_q.delete();
                end else begin
                    m_pos++;
                end
            end
            if (m_pub) begin
                if (!m_valid || m_xfer) begin
                    m_rate  = m_nr;
                    m_isi   = m_ni;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_xfer) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            n_vec++;
            if ({rate, isi, valid, ovr, busy} !==
                {CNT_W'(m_rate), CNT_W'(m_isi), m_valid, m_ovr, m_run}) begin
                n_err++;
                $display("FAIL cycle t=%0t got rate=%0d isi=%0d v=%b ovr=%b busy=%b exp rate=%0d isi=%0d v=%b ovr=%b busy=%b",
                         $time, rate, isi, valid, ovr, busy,
                         m_rate, m_isi, m_valid, m_ovr, m_run);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        en = 1'b1;
        tick();
    endtask

    task automatic window(input int len, input logic [63:0] pat,
                          input bit rdy_last);
        for (int c = 0; c <= len; c++) begin
            spk = pat[c];
            if (rdy_last && c == len) rdy = 1'b1;
            tick();
        end
        spk = 1'b0;
        if (rdy_last) rdy = 1'b0;
    endtask

    task automatic drain();
        en  = 1'b0;
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        chk_on = 1'b1;
        tick();
        tick();
        chk("reset valid", int'(valid), 0);
        chk("reset busy", int'(busy), 0);
        rst = 1'b0;
        tick();

        // basic: onsets at 0,3,8 in a 10-cycle window
        wlen = 8'd9;
        start();
        chk("basic busy", int'(busy), 1);
        chk("basic valid early", int'(valid), 0);
        window(9, 64'h109, 1'b0);
        chk("basic rate", int'(rate), 3);
        chk("basic isi", int'(isi), 5);
        chk("basic valid", int'(valid), 1);
        chk("model basic rate", m_rate, 3);
        chk("model basic isi", m_isi, 5);
        drain();
        chk("basic drained", int'(valid), 0);

        // level held 6 cycles counts once
        start();
        window(9, 64'h7E, 1'b0);
        chk("level rate", int'(rate), 1);
        chk("level isi", int'(isi), 0);
        drain();

        // saturation: 32 onsets, every 2 cycles
        wlen = 8'd63;
        start();
        window(63, 64'h5555555555555555, 1'b0);
        chk("sat rate", int'(rate), 15);
        chk("sat isi", int'(isi), 2);
        chk("model sat rate", m_rate, 15);
        drain();

        // one-cycle windows
        wlen = 8'd0;
        start();
        window(0, 64'h1, 1'b0);
        chk("len0 rate", int'(rate), 1);
        chk("len0 isi", int'(isi), 0);
        drain();

        // ready only on the publish cycle of the second window
        wlen = 8'd4;
        start();
        window(4, 64'h01, 1'b0);
        chk("coin first rate", int'(rate), 1);
        window(4, 64'h15, 1'b1);
        chk("coin rate", int'(rate), 3);
        chk("coin isi", int'(isi), 2);
        chk("coin valid", int'(valid), 1);
        chk("coin ovr", int'(ovr), 0);
        drain();

        // backpressure: second result dropped
        wlen = 8'd7;
        start();
        window(7, 64'h05, 1'b0);
        window(7, 64'h55, 1'b0);
        chk("bp rate", int'(rate), 2);
        chk("bp isi", int'(isi), 2);
        chk("bp ovr", int'(ovr), 1);
        chk("bp valid", int'(valid), 1);
        drain();
        chk("bp drained", int'(valid), 0);
        chk("bp rate held", int'(rate), 2);

        // reset mid-window with a pending result
        wlen = 8'd9;
        start();
        window(9, 64'h109, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        en  = 1'b0;
        #1;
        chk("rst rate", int'(rate), 0);
        chk("rst isi", int'(isi), 0);
        chk("rst valid", int'(valid), 0);
        chk("rst ovr", int'(ovr), 0);
        chk("rst busy", int'(busy), 0);
        tick();
        rst = 1'b0;
        tick();
        start();
        chk("post-rst busy", int'(busy), 1);
        window(9, 64'h10, 1'b0);
        chk("post-rst rate", int'(rate), 1);
        chk("post-rst isi", int'(isi), 0);
        drain();

        // abort in window cycle 5
        start();
        for (int c = 0; c < 5; c++) begin
            spk = (c == 1 || c == 3);
            tick();
        end
        en  = 1'b0;
        spk = 1'b0;
        tick();
        chk("abort busy", int'(busy), 0);
        chk("abort valid", int'(valid), 0);
        tick();
        start();
        window(9, 64'h04, 1'b0);
        chk("abort new rate", int'(rate), 1);
        drain();

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 499) == 0) rst = 1'b1;
            if ($urandom_range(0, 99) < 3) en = ~en;
            if ($urandom_range(0, 2) == 0) spk = ~spk;
            if ($urandom_range(0, 19) == 0) spk = 1'b0;
            rdy = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 99) < 5)
                wlen = ($urandom_range(0, 3) == 0) ? 8'd0
                       : WIN_W'($urandom_range(1, 40));
            tick();
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
